// File: rtl/data_sram_slave_pkg.sv
// Shared constants and payload types for the data SRAM slave and its response queue.
package data_sram_slave_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int unsigned LATENCY_MIN     = 1;
    localparam int unsigned LATENCY_MAX     = 7;
    localparam int unsigned OUTSTANDING_MIN = 1;
    localparam int unsigned OUTSTANDING_MAX = 8;

    // Countdown width: holds LATENCY_MAX-1.
    localparam int unsigned CD_W = $clog2(LATENCY_MAX);

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_t;

endpackage

// File: rtl/data_sram_slave_resp_fifo.sv
// In-order response queue; every valid entry counts down from LATENCY-1 and is
// ready to retire at the head once its countdown reaches zero.
module resp_fifo
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned WIDTH   = 33,
    parameter int unsigned LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         head_done_c_o,
    output logic [WIDTH-1:0]             head_data_c_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CD_W-1:0]  cd_q   [DEPTH];
    logic [CD_W-1:0]  cd_d   [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_eff       = pop_i && vld_q[head_q];
    assign head_done_c_o = vld_q[head_q] && (cd_q[head_q] == '0);
    assign head_data_c_o = data_q[head_q];
    assign count_o       = count_q;

    // Next state: age all entries, retire at head, enqueue at tail.
    always_comb begin
        data_d  = data_q;
        cd_d    = cd_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (cd_q[i] != '0)) begin
                cd_d[i] = cd_q[i] - CD_W'(1);
            end
        end

        if (pop_eff) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end

        if (push_i) begin
            data_d[tail_q] = push_data_i;
            cd_d[tail_q]   = CD_W'(LATENCY - 1);
            vld_d[tail_q]  = 1'b1;
            tail_d         = ptr_inc(tail_q);
        end

        case ({push_i, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cd_q    <= cd_d;
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/data_sram_slave.sv
// Data-side SRAM slave: byte-strobed word memory with fixed-latency, in-order
// responses and a bounded number of outstanding requests.
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    // Out-of-range parameters are clamped to the supported bounds.
    localparam int unsigned LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                                    (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int unsigned OUT_C = (OUTSTANDING < OUTSTANDING_MIN) ? OUTSTANDING_MIN :
                                    (OUTSTANDING > OUTSTANDING_MAX) ? OUTSTANDING_MAX : OUTSTANDING;
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(OUT_C + 1);
    localparam int unsigned RSP_W = $bits(resp_t);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             head_done;
    resp_t            push_rsp;
    resp_t            head_rsp;
    logic             unused_c;

    assign idx      = data_sram_addr[IDX_W+1:2];
    assign accept   = data_sram_req && (count < CNT_W'(OUT_C));
    assign unused_c = ^{data_sram_size, data_sram_addr[31:IDX_W+2], data_sram_addr[1:0]};

    assign data_sram_addr_ok = accept;
    assign data_sram_data_ok = head_done;
    assign data_sram_rdata   = (head_done && !head_rsp.wr) ? head_rsp.rdata : 32'h0;

    // Read data is captured at acceptance; earlier writes are already in the array.
    assign push_rsp.wr    = data_sram_wr;
    assign push_rsp.rdata = mem_q[idx];

    // Strobed write; size does not gate lanes, and contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    resp_fifo #(
        .DEPTH   (OUT_C),
        .WIDTH   (RSP_W),
        .LATENCY (LAT_C)
    ) u_resp_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (accept),
        .push_data_i   (push_rsp),
        .pop_i         (head_done),
        .count_o       (count),
        .head_done_c_o (head_done),
        .head_data_c_o (head_rsp)
    );

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench for data_sram_slave: DUT0 at LATENCY=2, DUT1 at LATENCY=1,
// both with OUTSTANDING=2, checked against a queue/array reference model.
module tb_data_sram_slave;
    import data_sram_slave_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic        wr     [2];
    logic [1:0]  size   [2];
    logic [3:0]  wstrb  [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        addr_ok[2];
    logic        data_ok[2];
    logic [31:0] rdata  [2];

    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;

    exp_t        sbq [2][$];
    logic [31:0] mdl [2][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_slave #(.MEM_WORDS(1024), .LATENCY(2), .OUTSTANDING(2)) u_dut0 (
        .clk(clk), .reset(rst),
        .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_size(size[0]),
        .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0])
    );

    data_sram_slave #(.MEM_WORDS(1024), .LATENCY(1), .OUTSTANDING(2)) u_dut1 (
        .clk(clk), .reset(rst),
        .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_size(size[1]),
        .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=0x%h expected=0x%h", name, d, cyc, act, exp_v);
        end
    endtask

    // Monitor: retire/compare responses, check acceptance, and update the model on accepts.
    int          cnt_m;
    int          w_m;
    exp_t        e_m;
    logic        exp_ok_m;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                sbq[d].delete();
            end else begin
                cnt_m = sbq[d].size();
                if (data_ok[d]) begin
                    if (cnt_m == 0) begin
                        chk("spurious_data_ok", d, 32'(data_ok[d]), 32'h0);
                    end else begin
                        e_m = sbq[d].pop_front();
                        chk("data_ok_cycle", d, 32'(cyc), 32'(e_m.due));
                        chk("rdata", d, rdata[d], e_m.wr ? 32'h0 : e_m.rdata);
                    end
                end else begin
                    chk("rdata_idle", d, rdata[d], 32'h0);
                    if (cnt_m != 0 && sbq[d][0].due <= cyc) begin
                        chk("missing_data_ok", d, 32'(data_ok[d]), 32'h1);
                        void'(sbq[d].pop_front());
                    end
                end
                exp_ok_m = req[d] && (cnt_m < 2);
                chk("addr_ok", d, 32'(addr_ok[d]), 32'(exp_ok_m));
                if (req[d] && addr_ok[d]) begin
                    w_m      = int'((addr[d] >> 2) & 32'd1023);
                    e_m.wr    = wr[d];
                    e_m.rdata = mdl[d][w_m];
                    e_m.due   = cyc + lat_of(d);
                    sbq[d].push_back(e_m);
                    if (wr[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[d][b]) mdl[d][w_m][8*b +: 8] = wdata[d][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        req[d] = 1'b1; wr[d] = w; size[d] = sz; wstrb[d] = st; addr[d] = a; wdata[d] = wd;
        @(negedge clk); #1;
        while (!addr_ok[d] && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!addr_ok[d]) begin
            failures++;
            $display("FAIL accept_timeout dut%0d cyc=%0d addr=0x%h", d, cyc, a);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] ra;
    int          nd;
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0; wstrb[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known contents for every word the random phase touches.
        for (int w = 0; w < 32; w++) issue(0, 1'b1, SIZE_WORD, 4'hF, 32'(w << 2), $urandom);
        idle(3);

        // Read after write.
        issue(0, 1'b1, SIZE_WORD, 4'hF, 32'h40, 32'h12345678);
        idle(3);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0);
        idle(3);

        // Byte and half stores.
        issue(0, 1'b1, SIZE_BYTE, 4'b0010, 32'h41, 32'hAAAAAAAA);
        issue(0, 1'b1, SIZE_HALF, 4'b1100, 32'h42, 32'hBBBBBBBB);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0);
        idle(3);

        // Squashed store.
        issue(0, 1'b1, SIZE_WORD, 4'h0, 32'h40, 32'hFFFFFFFF);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0);
        idle(4);

        // Back-pressure: three reads with req held.
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h0, 32'h0);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h4, 32'h0);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h40, 32'h0);
        idle(4);

        // Reset with two reads in flight, then an immediate new read.
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h8, 32'h0);
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'hC, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 1'b0, SIZE_WORD, 4'h0, 32'h10, 32'h0);
        idle(5);

        // Randomized traffic with ignored upper/low address bits.
        for (int n = 0; n < 300; n++) begin
            ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            issue(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom), ra, $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        // LATENCY=1: back-to-back reads retire every cycle.
        issue(1, 1'b1, SIZE_WORD, 4'hF, 32'h0, $urandom);
        issue(1, 1'b1, SIZE_WORD, 4'hF, 32'h4, $urandom);
        for (int k = 0; k < 8; k++) issue(1, 1'b0, SIZE_WORD, 4'h0, 32'((k % 2) << 2), 32'h0);
        idle(3);

        nd = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && nd < 100) begin
            @(posedge clk);
            nd++;
        end
        if (nd >= 100) begin
            failures++;
            $display("FAIL drain_timeout cyc=%0d pending0=%0d pending1=%0d", cyc, sbq[0].size(), sbq[1].size());
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
